// File: rtl/led_pattern_gen_if.sv
// Control and LED drive signals of the LED pattern generator.
// The master side supplies enable and pattern select; the slave side (the generator)
// returns the LED drive and the step pulse.
interface led_pattern_gen_if #(
  parameter int unsigned LED_NUM = 4
) ();

  logic               en;
  logic [1:0]         mode;
  logic [LED_NUM-1:0] led;
  logic               step_pulse;

  modport master (
    output en,
    output mode,
    input  led,
    input  step_pulse
  );

  modport slave (
    input  en,
    input  mode,
    output led,
    output step_pulse
  );

endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler divides clk into step ticks, and each tick advances
// the LED output through the selected pattern (rotate left, rotate right, ping-pong, blink).
// All state freezes while en is low; mode is only looked at on step edges.
module led_pattern_gen #(
  parameter int unsigned LED_NUM     = 4,
  parameter int unsigned STEP_CYCLES = 50,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  led_pattern_gen_if.slave bus
);

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  typedef enum logic {
    DirUp,
    DirDown
  } dir_e;

  localparam logic [1:0] ModeRotL  = 2'b00;
  localparam logic [1:0] ModeRotR  = 2'b01;
  localparam logic [1:0] ModePing  = 2'b10;
  localparam logic [1:0] ModeBlink = 2'b11;

  localparam logic [CNT_W-1:0]   CntLast = CNT_W'(STEP_CYCLES - 1);
  localparam logic [LED_NUM-1:0] LedLsb  = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LedMsb  = {1'b1, {(LED_NUM-1){1'b0}}};

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_pulse_q;

  logic               step;
  logic [LED_NUM-1:0] start_led;
  logic [LED_NUM-1:0] adv_led;
  dir_e               adv_dir;

  // A step fires on the enabled edge where the prescaler sits at its last count.
  assign step = bus.en && (cnt_q == CntLast);

  // Prescaler next state: count while enabled, wrap on the step edge, hold otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.en) begin
      if (step) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Start pattern for the currently requested mode.
  always_comb begin
    start_led = '0;
    unique case (bus.mode)
      ModeRotL:  start_led = LedLsb;
      ModeRotR:  start_led = LedMsb;
      ModePing:  start_led = LedLsb;
      ModeBlink: start_led = '1;
      default:   start_led = '0;
    endcase
  end

  // One-step advance of the running pattern under the latched mode.
  always_comb begin
    adv_led = led_q;
    adv_dir = dir_q;
    unique case (mode_q)
      ModeRotL: adv_led = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
      ModeRotR: adv_led = {led_q[0], led_q[LED_NUM-1:1]};
      ModePing: begin
        // Direction flips as soon as an end LED is reached, so ends are shown only once.
        if (dir_q == DirUp) begin
          adv_led = led_q << 1;
          if (adv_led[LED_NUM-1]) begin
            adv_dir = DirDown;
          end
        end else begin
          adv_led = led_q >> 1;
          if (adv_led[0]) begin
            adv_dir = DirUp;
          end
        end
      end
      ModeBlink: adv_led = ~led_q;
      default:   adv_led = led_q;
    endcase
  end

  // FSM next state: on a step, load a start pattern (first step or mode change) or advance.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    if (step) begin
      unique case (state_q)
        StIdle: begin
          led_d   = start_led;
          mode_d  = bus.mode;
          dir_d   = DirUp;
          state_d = StRun;
        end
        StRun: begin
          if (bus.mode != mode_q) begin
            led_d  = start_led;
            mode_d = bus.mode;
            dir_d  = DirUp;
          end else begin
            led_d = adv_led;
            dir_d = adv_dir;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      dir_q        <= DirUp;
      mode_q       <= 2'b00;
      led_q        <= '0;
      cnt_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      led_q        <= led_d;
      cnt_q        <= cnt_d;
      step_pulse_q <= step;
    end
  end

  assign bus.led        = led_q;
  assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a 4-LED / 4-cycle instance exercises all patterns,
// pause, wrap-edge hold and async reset; an 8-LED / 1-cycle instance checks every-cycle steps.
module tb_led_pattern_gen;

  logic clk;
  logic rst_n;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [3:0] exp_a;

  led_pattern_gen_if #(.LED_NUM(4)) bus_a ();
  led_pattern_gen_if #(.LED_NUM(8)) bus_b ();

  led_pattern_gen #(
    .LED_NUM     (4),
    .STEP_CYCLES (4),
    .CNT_W       (32)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  led_pattern_gen #(
    .LED_NUM     (8),
    .STEP_CYCLES (1),
    .CNT_W       (4)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample shortly after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full step period on instance A: three quiet edges, then the new pattern with a pulse.
  task automatic step_a(input logic [3:0] nxt);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_hold_led", 32'(bus_a.led), 32'(exp_a));
      check("a_hold_pulse", 32'(bus_a.step_pulse), 32'd0);
    end
    tick();
    exp_a = nxt;
    check("a_step_led", 32'(bus_a.led), 32'(exp_a));
    check("a_step_pulse", 32'(bus_a.step_pulse), 32'd1);
  endtask

  task automatic run_rotate_left();
    exp_a = 4'b0000;
    step_a(4'b0001);
    step_a(4'b0010);
    step_a(4'b0100);
    step_a(4'b1000);
    step_a(4'b0001);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_a.en   = 1'b1;
    bus_a.mode = 2'b00;
    bus_b.en   = 1'b0;
    bus_b.mode = 2'b00;
    exp_a      = 4'b0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", 32'(bus_a.led), 32'd0);
    check("rst_pulse", 32'(bus_a.step_pulse), 32'd0);
    check("rst_cnt", dut_a.cnt_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotate-left from reset release
    run_rotate_left();
    step_a(4'b0010);
    step_a(4'b0100);

    // Mode switch to rotate-right, then blink
    bus_a.mode = 2'b01;
    step_a(4'b1000);
    step_a(4'b0100);
    bus_a.mode = 2'b11;
    step_a(4'b1111);
    step_a(4'b0000);
    step_a(4'b1111);

    // Ping-pong
    bus_a.mode = 2'b10;
    step_a(4'b0001);
    step_a(4'b0010);
    step_a(4'b0100);
    step_a(4'b1000);
    step_a(4'b0100);
    step_a(4'b0010);
    step_a(4'b0001);
    step_a(4'b0010);

    // Pause at cnt=1 for 10 cycles
    tick();
    check("pause_pre_cnt", dut_a.cnt_q, 32'd1);
    bus_a.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pause_led", 32'(bus_a.led), 32'(exp_a));
      check("pause_pulse", 32'(bus_a.step_pulse), 32'd0);
      check("pause_cnt", dut_a.cnt_q, 32'd1);
    end
    bus_a.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("resume_led", 32'(bus_a.led), 32'(exp_a));
      check("resume_pulse", 32'(bus_a.step_pulse), 32'd0);
    end
    tick();
    exp_a = 4'b0100;
    check("resume_step_led", 32'(bus_a.led), 32'(exp_a));
    check("resume_step_pulse", 32'(bus_a.step_pulse), 32'd1);

    // en low exactly on the wrap edge
    repeat (3) tick();
    check("wrap_pre_cnt", dut_a.cnt_q, 32'd3);
    bus_a.en = 1'b0;
    tick();
    check("wrap_hold_led", 32'(bus_a.led), 32'(exp_a));
    check("wrap_hold_pulse", 32'(bus_a.step_pulse), 32'd0);
    check("wrap_hold_cnt", dut_a.cnt_q, 32'd3);
    bus_a.en = 1'b1;
    tick();
    exp_a = 4'b1000;
    check("wrap_step_led", 32'(bus_a.led), 32'(exp_a));
    check("wrap_step_pulse", 32'(bus_a.step_pulse), 32'd1);

    // Asynchronous reset between edges, right after a step
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(bus_a.led), 32'd0);
    check("async_rst_pulse", 32'(bus_a.step_pulse), 32'd0);
    check("async_rst_cnt", dut_a.cnt_q, 32'd0);
    bus_a.mode = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    run_rotate_left();

    // Instance B: one step per enabled edge, rotate right over 8 LEDs
    bus_b.mode = 2'b01;
    bus_b.en   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] exp_b;
      exp_b = 8'h80 >> (i % 8);
      tick();
      check("b_led", 32'(bus_b.led), 32'(exp_b));
      check("b_pulse", 32'(bus_b.step_pulse), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
